// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the width-converting stream FIFO.
// Holds the default parameter values, the error bit indices and the width helpers.
package fifo_stream_pkg;

  localparam int DEF_SIZE      = 16;
  localparam int DEF_MEM_SIZE  = 16;
  localparam int DEF_PAR_WRITE = 2;
  localparam int DEF_PAR_READ  = 4;

  // Bit positions inside the optional sticky error vector
  localparam int ERR_CNT_IDX  = 0;
  localparam int ERR_STAB_IDX = 1;

  // Width of a counter able to hold the values 0..n inclusive
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of a pointer addressing 0..depth-1 (at least one bit)
  function automatic int ptr_w(input int depth);
    if (depth <= 1) begin
      return 1;
    end else begin
      return $clog2(depth);
    end
  endfunction

endpackage

// File: rtl/fifo_stream_ptr.sv
// Modulo-DEPTH pointer register with a variable-step advance.
// DEPTH need not be a power of two, so the wrap uses an explicit compare.
module fifo_stream_ptr
  import fifo_stream_pkg::*;
#(
  parameter int DEPTH  = DEF_MEM_SIZE,
  parameter int STEP_W = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      adv,
  input  logic [STEP_W-1:0]         step,
  output logic [ptr_w(DEPTH)-1:0]   ptr
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW + 1;

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] ptr_nxt_s;
  logic [AW-1:0] sum_s;

  // Next pointer value: add the step and fold back once past DEPTH
  always_comb begin
    sum_s     = {1'b0, ptr_r} + AW'(step);
    ptr_nxt_s = ptr_r;
    if (sum_s >= AW'(DEPTH)) begin
      sum_s     = sum_s - AW'(DEPTH);
      ptr_nxt_s = sum_s[PW-1:0];
    end else begin
      ptr_nxt_s = sum_s[PW-1:0];
    end
  end

  // Pointer register: clear wins over any advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= {PW{1'b0}};
    end else if (clear) begin
      ptr_r <= {PW{1'b0}};
    end else if (adv) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/fifo_stream_wc.sv
// Width-converting stream FIFO: up to PAR_WRITE words in, PAR_READ words out per beat.
// drain lets a partial final beat leave. Optional macro FIFO_STREAM_ERR_EN adds a
// sticky err[1:0] port flagging oversize in_cnt and source stability violations.
module fifo_stream_wc
  import fifo_stream_pkg::*;
#(
  parameter int SIZE       = DEF_SIZE,
  parameter int MEM_SIZE   = DEF_MEM_SIZE,
  parameter int PAR_WRITE  = DEF_PAR_WRITE,
  parameter int PAR_READ   = DEF_PAR_READ,
  parameter int AFULL_LVL  = MEM_SIZE - PAR_WRITE,
  parameter int AEMPTY_LVL = PAR_READ - 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SIZE*PAR_WRITE-1:0]      din,
  input  logic [cnt_w(PAR_WRITE)-1:0]    in_cnt,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SIZE*PAR_READ-1:0]       dout,
  output logic [cnt_w(PAR_READ)-1:0]     out_cnt,
  input  logic                           drain,
  output logic [cnt_w(MEM_SIZE)-1:0]     level,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic                           almost_empty
`ifdef FIFO_STREAM_ERR_EN
  ,
  output logic [1:0]                     err
`endif
);

  localparam int CIW = cnt_w(PAR_WRITE);
  localparam int COW = cnt_w(PAR_READ);
  localparam int LW  = cnt_w(MEM_SIZE);
  localparam int PW  = ptr_w(MEM_SIZE);
  localparam int AW  = PW + 1;

  logic [SIZE-1:0] mem_r [MEM_SIZE];
  logic [LW-1:0]   level_r;
  logic [PW-1:0]   wr_ptr_s;
  logic [PW-1:0]   rd_ptr_s;
  logic [CIW-1:0]  wr_cnt_s;
  logic            wr_fire_s;
  logic            rd_fire_s;
  logic            in_ready_s;
  logic            out_valid_s;
  logic [COW-1:0]  out_cnt_s;

  // Lane address: base pointer plus lane offset, folded modulo MEM_SIZE
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [PW-1:0] off);
    logic [AW-1:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= AW'(MEM_SIZE)) begin
      sum = sum - AW'(MEM_SIZE);
    end
    return sum[PW-1:0];
  endfunction

  // Handshake decode; everything here depends on registered level, never on in_cnt or out_ready
  always_comb begin
    in_ready_s  = (level_r <= LW'(MEM_SIZE - PAR_WRITE));
    out_valid_s = (level_r >= LW'(PAR_READ)) || (drain && (level_r != {LW{1'b0}}));
    if (!out_valid_s) begin
      out_cnt_s = {COW{1'b0}};
    end else if (level_r >= LW'(PAR_READ)) begin
      out_cnt_s = COW'(PAR_READ);
    end else begin
      out_cnt_s = level_r[COW-1:0];
    end
    if (in_cnt > CIW'(PAR_WRITE)) begin
      wr_cnt_s = CIW'(PAR_WRITE);
    end else begin
      wr_cnt_s = in_cnt;
    end
    wr_fire_s = in_valid && in_ready_s && !clear;
    rd_fire_s = out_valid_s && out_ready && !clear;
  end

  fifo_stream_ptr #(.DEPTH(MEM_SIZE), .STEP_W(CIW)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .adv   (wr_fire_s),
    .step  (wr_cnt_s),
    .ptr   (wr_ptr_s)
  );

  fifo_stream_ptr #(.DEPTH(MEM_SIZE), .STEP_W(COW)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .adv   (rd_fire_s),
    .step  (out_cnt_s),
    .ptr   (rd_ptr_s)
  );

  // Storage write: lanes below the clamped count land at consecutive wrapped addresses
  always_ff @(posedge clk) begin
    for (int i = 0; i < PAR_WRITE; i++) begin
      if (wr_fire_s && (CIW'(i) < wr_cnt_s)) begin
        mem_r[wrap_add(wr_ptr_s, PW'(i))] <= din[i*SIZE +: SIZE];
      end
    end
  end

  // Occupancy counter: add written words, subtract popped words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_r <= {LW{1'b0}};
    end else if (clear) begin
      level_r <= {LW{1'b0}};
    end else begin
      level_r <= level_r
               + (wr_fire_s ? LW'(wr_cnt_s)  : {LW{1'b0}})
               - (rd_fire_s ? LW'(out_cnt_s) : {LW{1'b0}});
    end
  end

  // Output lane mux: lanes past out_cnt are forced to zero
  always_comb begin
    dout = {(SIZE*PAR_READ){1'b0}};
    for (int j = 0; j < PAR_READ; j++) begin
      if (COW'(j) < out_cnt_s) begin
        dout[j*SIZE +: SIZE] = mem_r[wrap_add(rd_ptr_s, PW'(j))];
      end else begin
        dout[j*SIZE +: SIZE] = {SIZE{1'b0}};
      end
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = out_valid_s;
  assign out_cnt      = out_cnt_s;
  assign level        = level_r;
  assign full         = !in_ready_s;
  assign empty        = (level_r == {LW{1'b0}});
  assign almost_full  = (level_r >= LW'(AFULL_LVL));
  assign almost_empty = (level_r <= LW'(AEMPTY_LVL));

`ifdef FIFO_STREAM_ERR_EN
  logic [1:0]               err_r;
  logic                     stall_r;
  logic [SIZE*PAR_WRITE-1:0] din_q_r;
  logic [CIW-1:0]           cnt_q_r;

  // Sticky source-protocol monitor; a stalled beat must stay valid and unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r   <= 2'b00;
      stall_r <= 1'b0;
      din_q_r <= {(SIZE*PAR_WRITE){1'b0}};
      cnt_q_r <= {CIW{1'b0}};
    end else if (clear) begin
      err_r   <= 2'b00;
      stall_r <= 1'b0;
      din_q_r <= din;
      cnt_q_r <= in_cnt;
    end else begin
      if (in_valid && (in_cnt > CIW'(PAR_WRITE))) begin
        err_r[ERR_CNT_IDX] <= 1'b1;
      end
      if (stall_r && (!in_valid || (din != din_q_r) || (in_cnt != cnt_q_r))) begin
        err_r[ERR_STAB_IDX] <= 1'b1;
      end
      stall_r <= in_valid && !in_ready_s;
      din_q_r <= din;
      cnt_q_r <= in_cnt;
    end
  end

  assign err = err_r;
`endif

endmodule

// File: tb/tb_fifo_stream_wc.sv
// Self-checking bench for fifo_stream_wc (default parameters: 16-bit words,
// depth 16, 2 in / 4 out). A word queue is the reference model.
module tb_fifo_stream_wc;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, out_ready, drain;
  logic [31:0] din;
  logic [1:0]  in_cnt;
  logic        in_ready, out_valid, full, empty, almost_full, almost_empty;
  logic [63:0] dout;
  logic [2:0]  out_cnt;
  logic [4:0]  level;
`ifdef FIFO_STREAM_ERR_EN
  logic [1:0]  err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] q[$];
  logic [15:0] rx[$];
  logic [15:0] tx[$];

  always #5 clk = ~clk;

  fifo_stream_wc dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .in_cnt(in_cnt), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .out_cnt(out_cnt), .drain(drain), .level(level), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty)
`ifdef FIFO_STREAM_ERR_EN
    , .err(err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every status output with what the word queue implies
  task automatic check_model();
    int sz, oc;
    bit ov;
    logic [63:0] ed;
    sz = q.size();
    ov = (sz >= 4) || (drain && sz > 0);
    oc = ov ? ((sz < 4) ? sz : 4) : 0;
    ed = '0;
    for (int j = 0; j < oc; j++) ed[j*16 +: 16] = q[j];
    check("level",        level,        sz);
    check("in_ready",     in_ready,     (16 - sz) >= 2);
    check("full",         full,         (16 - sz) < 2);
    check("empty",        empty,        sz == 0);
    check("almost_full",  almost_full,  sz >= 14);
    check("almost_empty", almost_empty, sz <= 3);
    check("out_valid",    out_valid,    ov);
    check("out_cnt",      out_cnt,      oc);
    check("dout",         dout,         ed);
  endtask

  // One clock: called at negedge with inputs set, returns at next negedge
  task automatic step();
    int sz, oc, n;
    bit ov, wr, rd;
    if (rst) q.delete();
    #1;
    check_model();
    sz = q.size();
    ov = (sz >= 4) || (drain && sz > 0);
    oc = ov ? ((sz < 4) ? sz : 4) : 0;
    wr = !rst && in_valid && ((16 - sz) >= 2) && !clear;
    rd = !rst && ov && out_ready && !clear;
    if (rd) for (int j = 0; j < oc; j++) rx.push_back(dout[j*16 +: 16]);
    @(posedge clk);
    if (rst || clear) begin
      q.delete();
    end else begin
      if (rd) repeat (oc) void'(q.pop_front());
      if (wr) begin
        n = (in_cnt > 2) ? 2 : int'(in_cnt);
        for (int i = 0; i < n; i++) q.push_back(din[i*16 +: 16]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int guard;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; drain = 1'b0;
    din = '0; in_cnt = '0;

    // Reset
    @(negedge clk);
    repeat (3) step();
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dout", dout, 0);
    rst = 1'b0;
    step();

    // Basic transfer
    in_valid = 1'b1; in_cnt = 2'd2;
    for (int b = 0; b < 4; b++) begin
      din = {16'(2*b + 2), 16'(2*b + 1)};
      step();
      if (b == 1) check("basic_ovalid", out_valid, 1);
    end
    in_valid = 1'b0;
    check("basic_level", level, 8);
    out_ready = 1'b1;
    check("basic_rd0", dout, 64'h0004_0003_0002_0001);
    step();
    check("basic_rd1", dout, 64'h0008_0007_0006_0005);
    step();
    out_ready = 1'b0;

    // Backpressure
    in_valid = 1'b1; in_cnt = 2'd1; guard = 0;
    while (q.size() < 15 && guard < 40) begin
      din = {16'h0, 16'h0100 + 16'(q.size())};
      step();
      guard++;
    end
    check("bp_fill_level", level, 15);
    step();
    check("bp_in_ready", in_ready, 0);
    check("bp_full", full, 1);
    out_ready = 1'b1;
    step();
    check("bp_after_rd_level", level, 11);
    check("bp_after_rd_ready", in_ready, 1);
    in_valid = 1'b0; drain = 1'b1; guard = 0;
    while (q.size() > 0 && guard < 10) begin step(); guard++; end
    check("bp_drained", empty, 1);
    drain = 1'b0;

    // Wrap: 40 words streamed through with concurrent reads
    rx.delete(); tx.delete();
    in_valid = 1'b1; in_cnt = 2'd2; out_ready = 1'b1;
    for (int b = 0; b < 20; b++) begin
      din = $urandom;
      tx.push_back(din[15:0]); tx.push_back(din[31:16]);
      step();
      if (b >= 2) check("wrap_level_bound", level <= 5'd4, 1'b1);
    end
    in_valid = 1'b0; drain = 1'b1;
    repeat (3) step();
    drain = 1'b0;
    check("wrap_count", rx.size(), 40);
    for (int i = 0; i < 40 && i < rx.size(); i++) check("wrap_data", rx[i], tx[i]);

    // Drain of a partial beat
    out_ready = 1'b0; in_valid = 1'b1;
    din = {16'h000B, 16'h000A}; in_cnt = 2'd2; step();
    din = {16'h0000, 16'h000C}; in_cnt = 2'd1; step();
    in_valid = 1'b0; drain = 1'b1;
    #1;
    check("drain_ovalid", out_valid, 1);
    check("drain_ocnt", out_cnt, 3);
    check("drain_dout", dout, 64'h0000_000C_000B_000A);
    out_ready = 1'b1;
    step();
    check("drain_empty", empty, 1);
    drain = 1'b0; out_ready = 1'b0;

    // Clear with a pending write
    in_valid = 1'b1; in_cnt = 2'd2;
    repeat (3) begin din = $urandom; step(); end
    check("clr_pre_level", level, 6);
    clear = 1'b1; din = $urandom; step();
    clear = 1'b0; in_valid = 1'b0;
    check("clr_level", level, 0);
    check("clr_empty", empty, 1);
    step();

    // Randomised traffic with occasional clear and reset
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom % 3) != 0;
      in_cnt    = 2'($urandom % 4);
      din       = $urandom;
      out_ready = ($urandom % 2) != 0;
      drain     = ($urandom % 4) == 0;
      clear     = ($urandom % 60) == 0;
      rst       = ($urandom % 200) == 0;
      step();
    end
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; drain = 1'b0;
    step();

`ifdef FIFO_STREAM_ERR_EN
    // Error flags
    clear = 1'b1; step(); clear = 1'b0;
    check("err_cleared", err, 2'b00);
    in_valid = 1'b1; in_cnt = 2'd3; din = 32'h0022_0011; step();
    in_valid = 1'b0;
    check("err_cnt_set", err, 2'b01);
    check("err_clamp_level", level, 2);
    step(); step();
    check("err_cnt_sticky", err, 2'b01);
    clear = 1'b1; step(); clear = 1'b0;
    check("err_clear", err, 2'b00);
    in_valid = 1'b1; in_cnt = 2'd2; guard = 0;
    while (q.size() < 15 && guard < 20) begin din = $urandom; step(); guard++; end
    step();
    check("err_stab_hold", err, 2'b00);
    din = ~din; step();
    check("err_stab_set", err, 2'b10);
    in_valid = 1'b0; clear = 1'b1; step(); clear = 1'b0;
    check("err_stab_clear", err, 2'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
